// File: rtl/adc_frame_pkg.sv
// Shared constants and state encoding for the ADC frame builder.
package adc_frame_pkg;

   localparam int          ADC_WORD_NUM   = 16;
   localparam logic [15:0] ADC_FRAME_HEAD = 16'h55AA;
   localparam int          ADC_FIFO_NUM   = 8;

   typedef enum logic [3:0] {
      IDLE,
      HEAD,
      STAT,
      REQ,
      WAIT,
      DHI,
      DLO,
      CSUM,
      DONE
   } adc_state_t;

   function automatic logic [0:ADC_FIFO_NUM-1] fifo_sel(
      input logic [2:0] k
   );
      logic [0:ADC_FIFO_NUM-1] s;
      s    = '0;
      s[k] = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/adc_frame.sv
// Frame builder: header, latched status, 8 FIFOs of 16-bit words,
// and a trailing modulo-256 checksum, streamed as a valid/ready byte flow.
module adc_frame
   import adc_frame_pkg::*;
#(
   parameter int          WORD_NUM   = ADC_WORD_NUM,
   parameter logic [15:0] FRAME_HEAD = ADC_FRAME_HEAD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fs_read,
   output logic        fd_read,
   input  logic [31:0] cache_stat,
   output logic [0:7]  fifo_rxen,
   input  logic [0:63] fifo_rxd,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int WCW = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;

   adc_state_t     state;
   adc_state_t     state_nx;
   logic [1:0]     bcnt;
   logic [2:0]     idx;
   logic [WCW-1:0] wcnt;
   logic [7:0]     csum;
   logic [31:0]    stat;
   logic [15:0]    word;
   logic [7:0]     stat_byte;
   logic           xfer;
   logic           last_word;

   assign xfer      = tx_valid & tx_ready;
   assign last_word = (wcnt == WCW'(WORD_NUM - 1));

   always_comb begin
      stat_byte = stat[31:24];
      unique case (bcnt)
         2'd0: stat_byte = stat[31:24];
         2'd1: stat_byte = stat[23:16];
         2'd2: stat_byte = stat[15:8];
         2'd3: stat_byte = stat[7:0];
         default: stat_byte = stat[31:24];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Outputs decode from registered state only, so a stalled byte
   // holds valid and data steady until the sink takes it.
   always_comb begin
      state_nx  = state;
      fd_read   = 1'b0;
      fifo_rxen = '0;
      tx_valid  = 1'b0;
      tx_data   = '0;
      unique case (state)
         IDLE: begin
            if (fs_read) state_nx = HEAD;
         end
         HEAD: begin
            tx_valid = 1'b1;
            tx_data  = bcnt[0] ? FRAME_HEAD[7:0]
                               : FRAME_HEAD[15:8];
            if (tx_ready && bcnt[0]) state_nx = STAT;
         end
         STAT: begin
            tx_valid = 1'b1;
            tx_data  = stat_byte;
            if (tx_ready && bcnt == 2'd3) state_nx = REQ;
         end
         REQ: begin
            fifo_rxen = fifo_sel(idx);
            state_nx  = WAIT;
         end
         WAIT: begin
            state_nx = DHI;
         end
         DHI: begin
            tx_valid = 1'b1;
            tx_data  = word[15:8];
            if (tx_ready) state_nx = DLO;
         end
         DLO: begin
            tx_valid = 1'b1;
            tx_data  = word[7:0];
            if (tx_ready) begin
               if (last_word && idx == 3'd7) state_nx = CSUM;
               else                          state_nx = REQ;
            end
         end
         CSUM: begin
            tx_valid = 1'b1;
            tx_data  = csum;
            if (tx_ready) state_nx = DONE;
         end
         DONE: begin
            fd_read = 1'b1;
            if (!fs_read) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcnt <= '0;
         idx  <= '0;
         wcnt <= '0;
         csum <= '0;
         stat <= '0;
         word <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (fs_read) begin
                  stat <= cache_stat;
                  bcnt <= '0;
                  idx  <= '0;
                  wcnt <= '0;
                  csum <= '0;
               end
            end
            HEAD: begin
               if (xfer) bcnt <= bcnt[0] ? 2'd0 : 2'd1;
            end
            STAT: begin
               if (xfer) begin
                  bcnt <= bcnt + 2'd1;
                  csum <= csum + tx_data;
               end
            end
            WAIT: begin
               word <= fifo_rxd[{idx[2:1], 4'b0000} +: 16];
            end
            DHI: begin
               if (xfer) csum <= csum + tx_data;
            end
            DLO: begin
               if (xfer) begin
                  csum <= csum + tx_data;
                  if (last_word) begin
                     wcnt <= '0;
                     idx  <= idx + 3'd1;
                  end else begin
                     wcnt <= wcnt + WCW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_frame.sv
// Scoreboard bench for adc_frame: expected bytes are queued per frame
// and popped as the DUT transfers them.
module tb_adc_frame;
   import adc_frame_pkg::*;

   localparam int WN   = 16;
   localparam int FLEN = 7 + 16 * WN;

   logic        clk        = 1'b0;
   logic        rst        = 1'b0;
   logic        fs_read    = 1'b0;
   logic        fd_read;
   logic [31:0] cache_stat = '0;
   logic [0:7]  fifo_rxen;
   logic [0:63] fifo_rxd   = '0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   logic        rdy_fixed  = 1'b1;
   logic        rdy_rand   = 1'b1;
   logic        rand_mode  = 1'b0;
   bit          ptr_clr    = 1'b0;

   int          compared   = 0;
   int          mismatched = 0;
   int          nbytes     = 0;
   int          rxen_cnt   = 0;
   int          mode       = 0;
   int          ptr[8];
   logic [7:0]  last_byte  = '0;
   logic [7:0]  q[$];
   logic        pend       = 1'b0;
   logic [7:0]  pdata      = '0;

   always #5 clk = ~clk;

   assign tx_ready = rand_mode ? rdy_rand : rdy_fixed;

   adc_frame #(
      .WORD_NUM  (WN),
      .FRAME_HEAD(16'h55AA)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fs_read   (fs_read),
      .fd_read   (fd_read),
      .cache_stat(cache_stat),
      .fifo_rxen (fifo_rxen),
      .fifo_rxd  (fifo_rxd),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   function automatic logic [15:0] fval(int m, int k, int n);
      case (m)
         0:       return 16'h0100 + 16'(k * WN + n);
         2:       return {4'(k), 4'h0, 8'(n)};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(logic [31:0] st);
      logic [7:0]  cs;
      logic [15:0] w;
      cs = '0;
      q.push_back(8'h55);
      q.push_back(8'hAA);
      for (int i = 3; i >= 0; i--) begin
         q.push_back(st[8*i +: 8]);
         cs = cs + st[8*i +: 8];
      end
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < WN; n++) begin
            w = fval(mode, k, n);
            q.push_back(w[15:8]);
            q.push_back(w[7:0]);
            cs = cs + w[15:8] + w[7:0];
         end
      end
      q.push_back(cs);
   endtask

   // Bench FIFO model: one-cycle read latency, per-FIFO read pointer.
   always @(posedge clk) begin
      if (ptr_clr) begin
         for (int k = 0; k < 8; k++) ptr[k] <= 0;
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (fifo_rxen[k]) begin
               fifo_rxd[16*(k/2) +: 16] <= fval(mode, k, ptr[k]);
               ptr[k] <= ptr[k] + 1;
               rxen_cnt++;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      rdy_rand = ($urandom_range(0, 99) >= 30);
   end

   always @(negedge clk) begin
      if (rst && pend) begin
         chk("hold_valid", 32'(tx_valid), 32'd1);
         chk("hold_data", 32'(tx_data), 32'(pdata));
      end
      if (fifo_rxen != '0) begin
         chk("rxen_onehot", 32'($countones(fifo_rxen)), 32'd1);
         chk("rxen_while_tx", 32'(tx_valid), 32'd0);
      end
      if (tx_valid && tx_ready) begin
         nbytes++;
         last_byte = tx_data;
         if (q.size() == 0) chk("extra_byte", 32'(q.size()), 32'd1);
         else               chk("byte", 32'(tx_data), 32'(q.pop_front()));
      end
      pend  = tx_valid && !tx_ready;
      pdata = tx_data;
   end

   task automatic start_frame(logic [31:0] st, int m);
      mode       = m;
      cache_stat = st;
      ptr_clr    = 1'b1;
      @(posedge clk); #1;
      ptr_clr    = 1'b0;
      nbytes     = 0;
      rxen_cnt   = 0;
      push_frame(st);
      fs_read    = 1'b1;
      @(posedge clk); #1;
      cache_stat = ~st;
   endtask

   task automatic wait_done(string tag, int budget);
      int c;
      c = 0;
      while (!fd_read && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      chk(tag, 32'(fd_read), 32'd1);
   endtask

   task automatic end_frame(string tag, int budget, int hold);
      wait_done({tag, "_done"}, budget);
      chk({tag, "_len"}, 32'(nbytes), 32'(FLEN));
      chk({tag, "_rxen"}, 32'(rxen_cnt), 32'(8 * WN));
      chk({tag, "_queue"}, 32'(q.size()), 32'd0);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      if (hold > 0) begin
         chk({tag, "_hold_fd"}, 32'(fd_read), 32'd1);
         chk({tag, "_hold_len"}, 32'(nbytes), 32'(FLEN));
      end
      fs_read = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk({tag, "_fd_clr"}, 32'(fd_read), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      #12;
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_data", 32'(tx_data), 32'd0);
      chk("rst_fd", 32'(fd_read), 32'd0);
      chk("rst_rxen", 32'(fifo_rxen), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      start_frame(32'hDEADBEEF, 0);
      end_frame("ramp", 3000, 0);

      start_frame(32'h12345678, 1);
      end_frame("zero", 3000, 0);
      chk("zero_csum", 32'(last_byte), 32'h14);

      rand_mode = 1'b1;
      start_frame(32'hA5C30F1E, 0);
      end_frame("rand", 6000, 0);
      rand_mode = 1'b0;

      start_frame(32'h0BADF00D, 0);
      for (int c = 0; c < 3000 && nbytes < 100; c++) @(negedge clk);
      #1;
      chk("mid_reach", 32'(nbytes >= 100), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_valid", 32'(tx_valid), 32'd0);
      chk("mid_data", 32'(tx_data), 32'd0);
      chk("mid_fd", 32'(fd_read), 32'd0);
      chk("mid_rxen", 32'(fifo_rxen), 32'd0);
      q.delete();
      fs_read = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      start_frame(32'hCAFE0001, 2);
      end_frame("tag", 3000, 0);

      start_frame(32'h0F0F0F0F, 0);
      for (int c = 0; c < 3000 && nbytes < 50; c++) begin
         @(posedge clk); #1;
      end
      fs_read = 1'b0;
      @(posedge clk); #1;
      fs_read = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("pulse_busy", 32'(fd_read), 32'd0);
      end_frame("pulse", 3000, 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/adc_frame.md
ADC_FRAME -- requirements
Module: adc_frame

Interface
REQ-001 Parameter WORD_NUM, 16, words drained from each FIFO per frame.
REQ-002 Parameter FRAME_HEAD, 16'h55AA, frame header, sent MSB byte first.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 fs_read  in  1  frame start request, level.
REQ-006 fd_read  out  1  frame done, level.
REQ-007 cache_stat  in  32  device status word, included in the frame.
REQ-008 fifo_rxen  out  [0:7]  per-FIFO read strobe; FIFO k sits on device k/2.
REQ-009 fifo_rxd  in  [0:63]  FIFO read data; FIFO k data is fifo_rxd[16*(k/2) +: 16].
REQ-010 tx_data  out  8  output byte.
REQ-011 tx_valid  out  1  tx_data valid.
REQ-012 tx_ready  in  1  downstream accepts; a byte transfers when tx_valid and tx_ready are both 1 on an edge.

Function
REQ-013 States SHALL be IDLE, HEAD, STAT, REQ, WAIT, DHI, DLO, CSUM, DONE.
REQ-014 IDLE: when fs_read=1, latch cache_stat, clear word counter, FIFO index and checksum, then go to HEAD.
REQ-015 HEAD: send 0x55 then 0xAA. STAT: send the latched cache_stat bytes [31:24], [23:16], [15:8], [7:0].
REQ-016 REQ: assert fifo_rxen[idx] for exactly one cycle, then go to WAIT; at most one fifo_rxen bit SHALL ever be high.
REQ-017 WAIT: capture the 16-bit word from fifo_rxd one cycle after the strobe (fixed 1-cycle read latency), then go to DHI.
REQ-018 DHI/DLO: send word[15:8], then word[7:0].
REQ-019 After DLO, advance the word counter. When the counter reaches WORD_NUM-1, wrap it to 0 and increment idx. After idx 7 word WORD_NUM-1, go to CSUM; otherwise go to REQ.
REQ-020 Checksum SHALL be the 8-bit modulo-256 sum of every transferred byte after the header (stat bytes and data bytes).
REQ-021 CSUM: send the checksum byte, then go to DONE.
REQ-022 Total frame length SHALL be 7 + 16*WORD_NUM bytes; with the default WORD_NUM this is 263 bytes.
REQ-023 tx_valid SHALL stay high and tx_data SHALL stay stable until the byte is accepted; no byte is dropped or duplicated.
REQ-024 While a byte is pending, no FIFO read SHALL be issued. An indefinite tx_ready=0 stalls the frame with no side effects.
REQ-025 DONE: fd_read=1 while fs_read=1. When fs_read=0, return to IDLE and clear fd_read.
REQ-026 fs_read toggling outside IDLE/DONE SHALL be ignored; a new frame needs fs_read low→high, via DONE.
REQ-027 tx_valid=1 simultaneous with a state transition: the transfer is counted in the checksum exactly once.

Reset
REQ-028 On rst=0: state IDLE; fd_read, fifo_rxen, tx_valid, tx_data, counters, checksum and latched stat all 0.
REQ-029 Reset mid-frame SHALL abort the frame; the partial frame is not resumed, and the next frame restarts at HEAD.
REQ-030 Release is synchronous-safe: the first fs_read is sampled no earlier than the first edge after rst=1.

Structure
REQ-031 FRAME_HEAD, WORD_NUM default and the state encoding SHALL live in the shared adc constants package/header.
REQ-032 No sub-module is required; byte muxing and checksum stay in one always block plus the FSM.

Verification
REQ-033 Reset, then fs_read=1 with tx_ready=1 and FIFO words = 16'h0100+n → bytes 55 AA, stat, 01 00 01 01 …, correct checksum; 263 bytes total; fd_read=1.
REQ-034 cache_stat=32'h12345678, all FIFO data 0 → stat bytes 12 34 56 78; checksum 0x14.
REQ-035 tx_ready toggled randomly at 30 % → same byte sequence as REQ-033; fifo_rxen never high while tx_valid=1 and tx_ready=0.
REQ-036 rst=0 asserted at byte 100 → all outputs 0 within the same cycle; next fs_read yields a complete correct frame.
REQ-037 fs_read held high after DONE, then pulsed during a frame → exactly one frame per low→high cycle; fifo_rxen total pulses = 8*WORD_NUM = 128.
REQ-038 Each FIFO k preloaded with tag k in bits [15:12] → data appears in order k=0..7, 16 words each, one-hot fifo_rxen.
